// File: rtl/mandelbrot_axi_read_master.sv
// AXI4 read master: fetches a contiguous block of beats in fixed-size bursts
// and forwards the read data unchanged onto an AXI4-Stream output.
module mandelbrot_axi_read_master #(
    parameter int C_ADDR_WIDTH       = 64,
    parameter int C_DATA_WIDTH       = 512,
    parameter int C_XFER_BEATS_WIDTH = 32,
    parameter int C_BURST_LEN        = 64,
    parameter int C_MAX_OUTSTANDING  = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          ctrl_start,
    output logic                          ctrl_done,
    input  logic [C_ADDR_WIDTH-1:0]       ctrl_addr_offset,
    input  logic [C_XFER_BEATS_WIDTH-1:0] ctrl_xfer_beats,
    output logic                          m_axi_arvalid,
    input  logic                          m_axi_arready,
    output logic [C_ADDR_WIDTH-1:0]       m_axi_araddr,
    output logic [7:0]                    m_axi_arlen,
    input  logic                          m_axi_rvalid,
    output logic                          m_axi_rready,
    input  logic [C_DATA_WIDTH-1:0]       m_axi_rdata,
    input  logic                          m_axi_rlast,
    output logic                          m_axis_tvalid,
    input  logic                          m_axis_tready,
    output logic [C_DATA_WIDTH-1:0]       m_axis_tdata,
    output logic                          m_axis_tlast
);

    localparam int OUT_W       = $clog2(C_MAX_OUTSTANDING) + 1;
    localparam int BURST_SHIFT = $clog2(C_BURST_LEN);
    localparam logic [C_ADDR_WIDTH-1:0]       BURST_BYTES = C_ADDR_WIDTH'(C_BURST_LEN * (C_DATA_WIDTH / 8));
    localparam logic [7:0]                    FULL_LEN    = 8'(C_BURST_LEN - 1);
    localparam logic [C_XFER_BEATS_WIDTH-1:0] BEAT_MASK   = C_XFER_BEATS_WIDTH'(C_BURST_LEN - 1);
    localparam logic [C_XFER_BEATS_WIDTH-1:0] ONE         = C_XFER_BEATS_WIDTH'(1);
    localparam logic [OUT_W-1:0]              MAX_OUT     = OUT_W'(C_MAX_OUTSTANDING);
    localparam logic [OUT_W-1:0]              OUT_ONE     = OUT_W'(1);

    typedef enum logic [1:0] {IDLE, ACTIVE, DONE} state_t;

    state_t                         state, state_next;
    logic [C_ADDR_WIDTH-1:0]        addr;
    logic [C_XFER_BEATS_WIDTH-1:0]  beats_remaining;
    logic [C_XFER_BEATS_WIDTH-1:0]  bursts_to_issue;
    logic [7:0]                     last_len;
    logic [OUT_W-1:0]               outstanding;
    logic [C_XFER_BEATS_WIDTH-1:0]  bursts_calc;
    logic [7:0]                     last_len_calc;
    logic                           active, ar_hs, r_hs, rlast_hs, start_ok;

    assign active   = (state == ACTIVE);
    assign start_ok = (state == IDLE) && ctrl_start && (ctrl_xfer_beats != '0);

    // Burst count rounds up; the low byte of (beats-1) is enough for the final arlen.
    assign bursts_calc   = (ctrl_xfer_beats >> BURST_SHIFT)
                         + C_XFER_BEATS_WIDTH'((ctrl_xfer_beats & BEAT_MASK) != '0);
    assign last_len_calc = (ctrl_xfer_beats[7:0] - 8'd1) & FULL_LEN;

    assign m_axi_arvalid = active && (bursts_to_issue != '0) && (outstanding < MAX_OUT);
    assign m_axi_araddr  = addr;
    assign m_axi_arlen   = (bursts_to_issue == ONE) ? last_len :
                           (bursts_to_issue == '0)  ? 8'd0 : FULL_LEN;

    assign m_axi_rready  = m_axis_tready && active;
    assign m_axis_tvalid = m_axi_rvalid && active;
    assign m_axis_tdata  = m_axi_rdata;
    assign m_axis_tlast  = active && (beats_remaining == ONE);
    assign ctrl_done     = (state == DONE);

    assign ar_hs    = m_axi_arvalid && m_axi_arready;
    assign r_hs     = m_axi_rvalid && m_axi_rready;
    assign rlast_hs = r_hs && m_axi_rlast;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // The transfer ends on the rlast that drains the last outstanding burst.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (ctrl_start) begin
                    state_next = (ctrl_xfer_beats == '0) ? DONE : ACTIVE;
                end
            end
            ACTIVE: begin
                if (rlast_hs && (bursts_to_issue == '0) && (outstanding == OUT_ONE)) begin
                    state_next = DONE;
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr            <= '0;
            beats_remaining <= '0;
            bursts_to_issue <= '0;
            last_len        <= '0;
            outstanding     <= '0;
        end else if (start_ok) begin
            addr            <= ctrl_addr_offset;
            beats_remaining <= ctrl_xfer_beats;
            bursts_to_issue <= bursts_calc;
            last_len        <= last_len_calc;
            outstanding     <= '0;
        end else begin
            if (ar_hs) begin
                addr            <= addr + BURST_BYTES;
                bursts_to_issue <= bursts_to_issue - ONE;
            end
            if (r_hs && (beats_remaining != '0)) begin
                beats_remaining <= beats_remaining - ONE;
            end
            // A simultaneous issue and completion cancel out.
            case ({ar_hs, rlast_hs})
                2'b10:   if (outstanding != MAX_OUT) outstanding <= outstanding + OUT_ONE;
                2'b01:   if (outstanding != '0)      outstanding <= outstanding - OUT_ONE;
                default: outstanding <= outstanding;
            endcase
        end
    end

endmodule

// File: tb/tb_mandelbrot_axi_read_master.sv
// Testbench for mandelbrot_axi_read_master: an AXI slave model feeds R beats,
// a scoreboard holds the expected stream beats until the DUT emits them.
`timescale 1ns/1ps
module tb_mandelbrot_axi_read_master;

    localparam int AW = 64;
    localparam int DW = 512;
    localparam int XW = 32;
    localparam int BL = 64;
    localparam int MO = 16;
    localparam logic [63:0] BURST_BYTES = 64'h1000;

    typedef struct {
        logic [63:0] addr;
        int          beats;
        int          ars;
        int          last_len;
        bit          tready_rand;
        bit          arready_rand;
        bit          ar_sync;
        bit          poke_start;
        int          simul;
    } vec_t;

    typedef struct {
        logic [63:0] addr;
        int          len;
    } ar_t;

    typedef struct {
        logic [DW-1:0] data;
        logic          last;
    } beat_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          ctrl_start = 1'b0;
    logic          ctrl_done;
    logic [AW-1:0] ctrl_addr_offset = '0;
    logic [XW-1:0] ctrl_xfer_beats = '0;
    logic          m_axi_arvalid;
    logic          m_axi_arready = 1'b0;
    logic [AW-1:0] m_axi_araddr;
    logic [7:0]    m_axi_arlen;
    logic          m_axi_rvalid = 1'b0;
    logic          m_axi_rready;
    logic [DW-1:0] m_axi_rdata = '0;
    logic          m_axi_rlast = 1'b0;
    logic          m_axis_tvalid;
    logic          m_axis_tready = 1'b1;
    logic [DW-1:0] m_axis_tdata;
    logic          m_axis_tlast;

    int n_assert = 0;
    int n_fail = 0;
    int cyc = 0;

    bit          tready_rand = 0, arready_rand = 0, ar_sync = 0, arready_en = 1;
    bit          force_rvalid = 0, new_xfer = 0;
    int          r_allow = 1 << 30;
    logic [63:0] exp_base = '0;
    int          exp_ars = 0, exp_last_len = 0, xfer_beats = 0, s_cyc = 0;

    int ar_cnt = 0, ar_idx = 0, beats_out = 0, tlast_cnt = 0, done_cnt = 0, done_cyc = 0;
    int last_beat_cyc = 0, bursts_done = 0, simul_cnt = 0, arvalid_cnt = 0, pushed = 0, out_model = 0;
    ar_t   ar_q[$];
    beat_t sb[$];

    mandelbrot_axi_read_master dut (
        .clk              (clk),
        .rst              (rst),
        .ctrl_start       (ctrl_start),
        .ctrl_done        (ctrl_done),
        .ctrl_addr_offset (ctrl_addr_offset),
        .ctrl_xfer_beats  (ctrl_xfer_beats),
        .m_axi_arvalid    (m_axi_arvalid),
        .m_axi_arready    (m_axi_arready),
        .m_axi_araddr     (m_axi_araddr),
        .m_axi_arlen      (m_axi_arlen),
        .m_axi_rvalid     (m_axi_rvalid),
        .m_axi_rready     (m_axi_rready),
        .m_axi_rdata      (m_axi_rdata),
        .m_axi_rlast      (m_axi_rlast),
        .m_axis_tvalid    (m_axis_tvalid),
        .m_axis_tready    (m_axis_tready),
        .m_axis_tdata     (m_axis_tdata),
        .m_axis_tlast     (m_axis_tlast)
    );

    initial forever #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin : watchdog
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish (got running, required finished)");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic failNow(input string name);
        n_assert++;
        n_fail++;
        $display("[TB] FAIL %s: got event, expected none", name);
    endtask

    // Slave model: handshakes are observed on the falling edge, new inputs are
    // driven just after the rising edge so they are stable for the next sample.
    initial begin : slave
        bit    beat_held, ar_pend, ar_hs, rl_hs;
        logic [63:0] pend_addr;
        logic [7:0]  pend_len;
        int    r_beat;
        beat_t e;
        beat_held = 0; ar_pend = 0; r_beat = 0; pend_addr = '0; pend_len = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                ar_q.delete(); sb.delete();
                beat_held = 0; ar_pend = 0; r_beat = 0; out_model = 0; pushed = 0; ar_idx = 0;
            end else begin
                if (ctrl_start && new_xfer) begin
                    pushed = 0;
                    ar_idx = 0;
                end
                ar_hs = m_axi_arvalid && m_axi_arready;
                rl_hs = m_axi_rvalid && m_axi_rready && m_axi_rlast;
                if (m_axi_arvalid) begin
                    arvalid_cnt++;
                    checkOutput("ar_within_limit", 64'(out_model < MO), 64'd1);
                end
                if (ar_pend) begin
                    checkOutput("ar_hold_valid", 64'(m_axi_arvalid), 64'd1);
                    checkOutput("ar_hold_addr", m_axi_araddr, pend_addr);
                    checkOutput("ar_hold_len", 64'(m_axi_arlen), 64'(pend_len));
                end
                if (ar_hs) begin
                    checkOutput("ar_addr", m_axi_araddr, exp_base + 64'(ar_idx) * BURST_BYTES);
                    checkOutput("ar_len", 64'(m_axi_arlen), (ar_idx == exp_ars - 1) ? 64'(exp_last_len) : 64'(BL - 1));
                    ar_q.push_back('{m_axi_araddr, int'(m_axi_arlen)});
                    ar_idx++; ar_cnt++; out_model++;
                end
                if (m_axi_rvalid && m_axi_rready) begin
                    checkOutput("axis_tvalid", 64'(m_axis_tvalid), 64'd1);
                    if (sb.size() == 0) begin
                        failNow("scoreboard_underflow");
                    end else begin
                        e = sb.pop_front();
                        n_assert++;
                        if (m_axis_tdata !== e.data) begin
                            n_fail++;
                            $display("[TB] FAIL axis_tdata: got %h, expected %h", m_axis_tdata, e.data);
                        end
                        checkOutput("axis_tlast", 64'(m_axis_tlast), 64'(e.last));
                    end
                    beat_held = 0;
                    beats_out++;
                    if (m_axis_tlast) begin
                        tlast_cnt++;
                        last_beat_cyc = cyc;
                    end
                    if (m_axi_rlast) begin
                        void'(ar_q.pop_front());
                        r_beat = 0; bursts_done++; out_model--;
                    end else begin
                        r_beat++;
                    end
                end
                if (ar_hs && rl_hs) simul_cnt++;
                ar_pend   = m_axi_arvalid && !m_axi_arready;
                pend_addr = m_axi_araddr;
                pend_len  = m_axi_arlen;
                if (ctrl_done) begin
                    done_cnt++;
                    done_cyc = cyc;
                end
            end

            @(posedge clk);
            #1;
            if (!rst && !beat_held && ar_q.size() > 0 && bursts_done < r_allow &&
                (!tready_rand || $urandom_range(0, 1) == 1)) begin
                for (int w = 0; w < DW / 32; w++) m_axi_rdata[w*32 +: 32] = $urandom();
                m_axi_rlast = (r_beat == ar_q[0].len);
                sb.push_back('{m_axi_rdata, logic'(pushed == xfer_beats - 1)});
                pushed++;
                beat_held = 1;
            end
            m_axi_rvalid  = beat_held || force_rvalid;
            m_axis_tready = tready_rand ? 1'($urandom_range(0, 1)) : 1'b1;
            if (ar_sync)
                m_axi_arready = (ar_q.size() == 0) || (beat_held && m_axi_rlast && m_axis_tready);
            else if (arready_rand)
                m_axi_arready = 1'($urandom_range(0, 1));
            else
                m_axi_arready = arready_en;
        end
    end

    task automatic applyStimulus(input logic [63:0] addr, input int beats, input bit is_new);
        @(posedge clk); #2;
        ctrl_addr_offset = addr;
        ctrl_xfer_beats  = XW'(beats);
        new_xfer         = is_new;
        ctrl_start       = 1'b1;
        if (is_new) s_cyc = cyc;
        @(posedge clk); #2;
        ctrl_start = 1'b0;
    endtask

    task automatic waitDone(input int d0, input int limit);
        int i;
        i = 0;
        while (done_cnt == d0 && i < limit) begin
            @(posedge clk);
            i++;
        end
        if (done_cnt == d0) failNow("done_timeout");
    endtask

    task automatic runVec(input vec_t v);
        int a0, b0, t0, d0, s0;
        tready_rand = v.tready_rand; arready_rand = v.arready_rand; ar_sync = v.ar_sync; arready_en = 1;
        exp_base = v.addr; exp_ars = v.ars; exp_last_len = v.last_len; xfer_beats = v.beats;
        a0 = ar_cnt; b0 = beats_out; t0 = tlast_cnt; d0 = done_cnt; s0 = simul_cnt;
        applyStimulus(v.addr, v.beats, 1);
        if (v.poke_start) begin
            repeat (20) @(posedge clk);
            applyStimulus(64'h7777_0000, 5, 0);
        end
        waitDone(d0, 5000);
        repeat (4) @(posedge clk);
        checkOutput("xfer_ar_count", 64'(ar_cnt - a0), 64'(v.ars));
        checkOutput("xfer_beat_count", 64'(beats_out - b0), 64'(v.beats));
        checkOutput("xfer_tlast_count", 64'(tlast_cnt - t0), 64'd1);
        checkOutput("xfer_done_pulses", 64'(done_cnt - d0), 64'd1);
        checkOutput("xfer_done_latency", 64'(done_cyc), 64'(last_beat_cyc + 1));
        checkOutput("xfer_sb_empty", 64'(sb.size()), 64'd0);
        if (v.simul >= 0) checkOutput("xfer_simultaneous_hs", 64'(simul_cnt - s0), 64'(v.simul));
        tready_rand = 0; arready_rand = 0; ar_sync = 0;
    endtask

    initial begin : main
        vec_t vecs[6];
        int   a0, b0, t0, d0, v0;

        vecs[0] = '{64'h1000,  1,   1, 0,  0, 0, 0, 0, -1};
        vecs[1] = '{64'h0,     130, 3, 1,  0, 0, 0, 0, -1};
        vecs[2] = '{64'h40000, 64,  1, 63, 0, 1, 0, 0, -1};
        vecs[3] = '{64'h8000,  65,  2, 0,  1, 1, 0, 0, -1};
        vecs[4] = '{64'h10000, 200, 4, 7,  1, 1, 0, 1, -1};
        vecs[5] = '{64'h3000,  192, 3, 63, 1, 0, 1, 0, 2};

        repeat (3) @(posedge clk);
        #2;
        checkOutput("reset_done", 64'(ctrl_done), 64'd0);
        checkOutput("reset_arvalid", 64'(m_axi_arvalid), 64'd0);
        checkOutput("reset_araddr", m_axi_araddr, 64'd0);
        checkOutput("reset_arlen", 64'(m_axi_arlen), 64'd0);
        checkOutput("reset_rready", 64'(m_axi_rready), 64'd0);
        checkOutput("reset_tvalid", 64'(m_axis_tvalid), 64'd0);
        checkOutput("reset_tlast", 64'(m_axis_tlast), 64'd0);
        rst = 1'b0;

        // Read data offered while idle must not be accepted.
        repeat (2) @(posedge clk);
        #2 force_rvalid = 1;
        repeat (2) @(posedge clk);
        #3;
        checkOutput("idle_rready", 64'(m_axi_rready), 64'd0);
        checkOutput("idle_tvalid", 64'(m_axis_tvalid), 64'd0);
        force_rvalid = 0;

        for (int i = 0; i < 6; i++) runVec(vecs[i]);

        // Zero-length transfer: no AR traffic, done on the cycle after start.
        xfer_beats = 0;
        a0 = ar_cnt; d0 = done_cnt; v0 = arvalid_cnt;
        applyStimulus(64'h5000, 0, 1);
        waitDone(d0, 20);
        repeat (3) @(posedge clk);
        checkOutput("zero_done_cycle", 64'(done_cyc), 64'(s_cyc + 1));
        checkOutput("zero_done_pulses", 64'(done_cnt - d0), 64'd1);
        checkOutput("zero_no_arvalid", 64'(arvalid_cnt - v0), 64'd0);
        checkOutput("zero_no_ar", 64'(ar_cnt - a0), 64'd0);

        // Slave withholds R: issue stops at the outstanding limit.
        exp_base = 64'h100000; exp_ars = 20; exp_last_len = 63; xfer_beats = 1280; arready_en = 1;
        r_allow = bursts_done;
        a0 = ar_cnt; b0 = beats_out; t0 = tlast_cnt; d0 = done_cnt;
        applyStimulus(64'h100000, 1280, 1);
        repeat (40) @(posedge clk);
        #2;
        checkOutput("hold_ar_count", 64'(ar_cnt - a0), 64'(MO));
        checkOutput("hold_arvalid_low", 64'(m_axi_arvalid), 64'd0);
        r_allow = bursts_done + 1;
        repeat (100) @(posedge clk);
        #2;
        checkOutput("hold_one_more_ar", 64'(ar_cnt - a0), 64'(MO + 1));
        checkOutput("hold_arvalid_low_again", 64'(m_axi_arvalid), 64'd0);
        r_allow = 1 << 30;
        waitDone(d0, 3000);
        repeat (4) @(posedge clk);
        checkOutput("hold_total_ar", 64'(ar_cnt - a0), 64'd20);
        checkOutput("hold_total_beats", 64'(beats_out - b0), 64'd1280);
        checkOutput("hold_tlast_count", 64'(tlast_cnt - t0), 64'd1);

        // Reset in the middle of a transfer while an AR is pending.
        exp_base = 64'h200000; exp_ars = 20; exp_last_len = 63; xfer_beats = 1280; arready_en = 0;
        applyStimulus(64'h200000, 1280, 1);
        repeat (3) @(posedge clk);
        #2;
        checkOutput("midrst_arvalid_before", 64'(m_axi_arvalid), 64'd1);
        rst = 1'b1;
        #1;
        checkOutput("midrst_arvalid", 64'(m_axi_arvalid), 64'd0);
        checkOutput("midrst_rready", 64'(m_axi_rready), 64'd0);
        checkOutput("midrst_araddr", m_axi_araddr, 64'd0);
        repeat (2) @(posedge clk);
        #2 rst = 1'b0;
        arready_en = 1;
        runVec('{64'h2000, 130, 3, 1, 0, 0, 0, 0, -1});

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
